button_debouncer_array: RTL
===========================

# button_debouncer_array

Parametrised N-channel button conditioner for the Sudoku controller: synchronises raw push-buttons, debounces press and release, emits one-cycle press pulses with configurable hold-to-repeat, and exposes a debounced level per channel. Sits between the board pins and the game-control FSM and replaces per-button single-channel debouncer instances with one block. The global `block` input and the per-channel repeat mask let the controller lock input during animations and limit auto-repeat to navigation keys.

## Interface
- `CHANNELS`, 5: number of independent button channels (≥1).
- `DEBOUNCE_CYCLES`, 50: consecutive stable synchronised samples required to accept a press or a release (≥1).
- `REPEAT_DELAY`, 24_999_999: hold cycles after the press pulse before the first repeat pulse (500 ms @ 50 MHz).
- `REPEAT_PERIOD`, 7_999_999: cycles between repeat pulses (160 ms @ 50 MHz; ≥2).
- `ACCEL_AFTER`, 8: repeat pulses before acceleration (used only with `BTN_REPEAT_ACCEL_EN`).
- `clk` in 1: system clock.
- `reset_fixed` in 1: asynchronous, active-low reset.
- `block` in 1: global input lock.
- `repeat_en` in CHANNELS: per-channel auto-repeat enable, sampled every cycle.
- `btn_in` in CHANNELS: raw buttons, 1 = pressed, asynchronous.
- `btn_press` out CHANNELS: one-cycle pulse per accepted press or repeat.
- `btn_level` out CHANNELS: debounced pressed state.
- `any_press` out 1: registered OR of the `btn_press` next-state values; high in the same cycle as `btn_press`.

## Operation
- Each bit of `btn_in` passes through a 2-FF synchroniser. All decisions use the synchronised value `s[i]`.
- Each channel runs its own FSM with a counter sized to `$clog2` of the largest of `DEBOUNCE_CYCLES`, `REPEAT_DELAY` and `REPEAT_PERIOD`, plus 1 bit.
- States:
  - IDLE: if `s=1` and `!block`, go to PRESS_DEB with counter=1.
  - PRESS_DEB:
    - If `s=0` or `block`, go to IDLE.
    - Else if counter ≥ `DEBOUNCE_CYCLES`, pulse `btn_press`, set `btn_level`=1, counter=0, go to HOLD.
    - Else increment the counter.
  - HOLD:
    - If `s=0`, go to RELEASE_DEB with counter=0.
    - Else if `repeat_en[i]=0`, the counter stays at 0.
    - Else if counter ≥ `REPEAT_DELAY`−1, pulse, counter=0, go to REPEAT.
    - Else increment the counter.
  - REPEAT: same as HOLD, but the threshold is the active period. When `repeat_en[i]` drops, return to HOLD with counter=0.
  - RELEASE_DEB:
    - If `s=1`, counter=0.
    - Else if counter ≥ `DEBOUNCE_CYCLES`, set `btn_level`=0 and go to IDLE.
    - Else increment the counter.
- `block` asserted in HOLD or REPEAT: move to RELEASE_DEB with counter=0 and suppress all pulses. A new press is accepted only after release plus re-press.
- Channels are fully independent. Simultaneous presses on several channels produce simultaneous pulses; there is no arbitration.
- Illegal state encoding: return to IDLE with outputs 0.

## Timing
- Reset (asynchronous, any state, including mid-debounce): all FSMs go to IDLE, counters 0, synchronisers 0, `btn_press`=0, `btn_level`=0, `any_press`=0.
- Press latency: take edge 0 as the first edge that samples `btn_in` high, with the input held high. `btn_press` and `btn_level` rise after edge `DEBOUNCE_CYCLES`+2.
- `btn_press` is never high for two consecutive cycles.
- The first repeat pulse comes exactly `REPEAT_DELAY` cycles after the press pulse. Later repeat pulses come every `REPEAT_PERIOD` cycles.
- Release latency: `btn_level` falls `DEBOUNCE_CYCLES`+3 edges after the first edge sampling `btn_in` low.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles after synchronisation produces no pulse and no level change.

## Configuration
- `BTN_REPEAT_ACCEL_EN` defined:
  - Each channel keeps a saturating repeat count, cleared on entry to HOLD.
  - After `ACCEL_AFTER` repeat pulses, the active period becomes `REPEAT_PERIOD`>>1.
- `BTN_REPEAT_ACCEL_EN` undefined: the period is always `REPEAT_PERIOD`, the repeat count logic is absent, and `ACCEL_AFTER` is ignored.

## Structure
- Shared package `sudoku_ctrl_pkg` holds:
  - the channel state enum (IDLE, PRESS_DEB, HOLD, REPEAT, RELEASE_DEB);
  - default timing constants;
  - channel index constants (BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, BTN_SEL).
- Sub-module `btn_channel_fsm` contains the synchroniser, counter and FSM for one channel. The top module instantiates it `CHANNELS` times and ORs the pulses into `any_press`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8, `ACCEL_AFTER`=2, `CHANNELS`=3.
- Clean press on ch0 held 10 cycles, `repeat_en`=0 → single `btn_press[0]` after edge 6; `btn_level[0]` falls 7 edges after release.
- Bounce on ch1, toggling every 2 cycles for 12 cycles, then low → no `btn_press`; `btn_level` stays 0.
- Hold ch2 with `repeat_en[2]`=1 for 60 cycles → pulses at edge 6, 26, 34, 42, 50, 58. With `BTN_REPEAT_ACCEL_EN`: 6, 26, 34, 38, 42, 46, 50, 54, 58.
- Raise `block` while ch0 is in REPEAT, then drop it with the button still held → no further pulses until release plus re-press.
- Simultaneous press on ch0 and ch1 → both pulses in the same cycle; `any_press` is one pulse.
- Assert reset mid-PRESS_DEB, then release it with the button held → all outputs 0 during reset; a fresh press pulse follows the full latency counted from the first sampling edge after reset release.

Source files
------------

// File: rtl/sudoku_ctrl_pkg.sv
// sudoku_ctrl_pkg: shared types and constants for the Sudoku controller button path
package sudoku_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_DEB,
    ST_HOLD,
    ST_REPEAT,
    ST_RELEASE_DEB
  } btn_state_e;

  localparam int DEF_CHANNELS        = 5;
  localparam int DEF_DEBOUNCE_CYCLES = 50;
  localparam int DEF_REPEAT_DELAY    = 24_999_999;
  localparam int DEF_REPEAT_PERIOD   = 7_999_999;
  localparam int DEF_ACCEL_AFTER     = 8;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_SEL   = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_channel_fsm.sv
// btn_channel_fsm: one button channel (synchroniser, debounce/repeat counter, FSM); BTN_REPEAT_ACCEL_EN halves the repeat period after ACCEL_AFTER repeats
module btn_channel_fsm
  import sudoku_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
`ifdef BTN_REPEAT_ACCEL_EN
  parameter int ACCEL_AFTER     = DEF_ACCEL_AFTER,
`endif
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset_fixed,
  input  logic block_i,
  input  logic repeat_en_i,
  input  logic btn_i,
  output logic press_o,
  output logic press_d_o,
  output logic level_o
);

  localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t DEB_TH  = cnt_t'(DEBOUNCE_CYCLES);
  localparam cnt_t DLY_TH  = cnt_t'(REPEAT_DELAY - 1);
  localparam cnt_t PER_TH  = cnt_t'(REPEAT_PERIOD - 1);

  logic [1:0] sync_q;
  logic       s;
  btn_state_e state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  cnt_t       rep_th;
  logic       press_q, press_d;
  logic       level_q, level_d;

  assign s = sync_q[1];

  // Two-flop synchroniser for the asynchronous pin
  always_ff @(posedge clk or negedge reset_fixed)
    if (!reset_fixed) sync_q <= '0;
    else sync_q <= {sync_q[0], btn_i};

`ifdef BTN_REPEAT_ACCEL_EN
  localparam int AW = $clog2(ACCEL_AFTER + 1) + 1;
  typedef logic [AW-1:0] rcnt_t;
  localparam rcnt_t ACC_TH  = rcnt_t'(ACCEL_AFTER);
  localparam cnt_t  FAST_TH = cnt_t'((REPEAT_PERIOD >> 1) - 1);
  rcnt_t rcnt_q, rcnt_d;

  // Saturating repeat-pulse count, restarted whenever the channel enters HOLD
  always_comb
    rcnt_d = (state_d == ST_HOLD && state_q != ST_HOLD) ? '0 :
             (press_d && state_q != ST_PRESS_DEB && rcnt_q < ACC_TH) ? rcnt_q + 1'b1 : rcnt_q;

  // Repeat count register
  always_ff @(posedge clk or negedge reset_fixed)
    if (!reset_fixed) rcnt_q <= '0;
    else rcnt_q <= rcnt_d;

  assign rep_th = (rcnt_q >= ACC_TH) ? FAST_TH : PER_TH;
`else
  assign rep_th = PER_TH;
`endif

  // Next-state logic: debounce press/release, count hold time, emit pulses
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    level_d = level_q;
    case (state_q)
      ST_IDLE:
        if (s && !block_i) begin
          state_d = ST_PRESS_DEB;
          cnt_d   = cnt_t'(1);
        end
      ST_PRESS_DEB:
        if (!s || block_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= DEB_TH) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          press_d = 1'b1;
          level_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      ST_HOLD, ST_REPEAT:
        if (!s || block_i) begin
          state_d = ST_RELEASE_DEB;
          cnt_d   = '0;
        end else if (!repeat_en_i) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (cnt_q >= ((state_q == ST_HOLD) ? DLY_TH : rep_th)) begin
          state_d = ST_REPEAT;
          cnt_d   = '0;
          press_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      ST_RELEASE_DEB:
        if (s) cnt_d = '0;
        else if (cnt_q >= DEB_TH) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end else cnt_d = cnt_q + 1'b1;
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clk or negedge reset_fixed)
    if (!reset_fixed) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      level_q <= level_d;
    end

  assign press_o   = press_q;
  assign press_d_o = press_d;
  assign level_o   = level_q;

endmodule

// File: rtl/button_debouncer_array.sv
// button_debouncer_array: N independent button channels with press pulses, levels and a combined any_press; BTN_REPEAT_ACCEL_EN enables repeat acceleration
module button_debouncer_array
  import sudoku_ctrl_pkg::*;
#(
  parameter int CHANNELS        = DEF_CHANNELS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int ACCEL_AFTER     = DEF_ACCEL_AFTER
) (
  input  logic                clk,
  input  logic                reset_fixed,
  input  logic                block,
  input  logic [CHANNELS-1:0] repeat_en,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_level,
  output logic                any_press
);

  logic [CHANNELS-1:0] press_d;
  logic                any_press_q;

  if (CHANNELS < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 2 || ACCEL_AFTER < 0) begin : g_bad_params
    $error("button_debouncer_array: illegal parameter value");
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    btn_channel_fsm #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
`ifdef BTN_REPEAT_ACCEL_EN
      .ACCEL_AFTER    (ACCEL_AFTER),
`endif
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk        (clk),
      .reset_fixed(reset_fixed),
      .block_i    (block),
      .repeat_en_i(repeat_en[c]),
      .btn_i      (btn_in[c]),
      .press_o    (btn_press[c]),
      .press_d_o  (press_d[c]),
      .level_o    (btn_level[c])
    );
  end

  // Register the OR of next-state pulses so any_press lines up with btn_press
  always_ff @(posedge clk or negedge reset_fixed)
    if (!reset_fixed) any_press_q <= 1'b0;
    else any_press_q <= |press_d;

  assign any_press = any_press_q;

endmodule
